adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arb_pkg.sv | 6 +
 rtl/adder_arbiter_add.sv | 12 +
 rtl/adder_arbiter.sv | 81 ++++++++
 tb/tb_adder_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared FSM state encoding and default operand width for adder_arbiter.
package adder_arb_pkg;
    localparam int ADDER_ARB_WIDTH = 32;
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;
endpackage

// File: rtl/adder_arbiter_add.sv
// adder_arbiter_add: combinational WIDTH-bit adder, carry out dropped.
module adder_arbiter_add
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = ADDER_ARB_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: two-requester round-robin adder with a one-entry result register.
// Define ADDER_ARB_OVF_EN to register the signed-overflow flag on rsp_ovf; otherwise it is tied to 0.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = ADDER_ARB_WIDTH,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_id,
    output logic                  rsp_ovf
);
    logic [0:0]       state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] add_a, add_b, add_s;
    logic             gnt, accept;

    always_comb begin
        gnt       = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        accept    = ~rst & (|req_valid) & ((state_q == ST_EMPTY) | rsp_ready);
        req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        add_a     = gnt ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
        add_b     = gnt ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
        state_d   = accept ? ST_FULL : (rsp_ready ? ST_EMPTY : state_q);
        last_d    = accept ? gnt : last_q;
        id_d      = accept ? gnt : id_q;
        sum_d     = accept ? add_s : sum_q;
    end

    adder_arbiter_add #(.WIDTH(WIDTH)) u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_s)
    );

    // last_q resets to 1 so requester 0 wins the first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;

`ifdef ADDER_ARB_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = accept ? ((add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_s[WIDTH-1] != add_a[WIDTH-1])) : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign rsp_ovf = ovf_q;
`else
    assign rsp_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed vector table, hand sequences and a randomized model comparison for adder_arbiter.
module tb_adder_arbiter;
    localparam int W = 32;
`ifdef ADDER_ARB_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     req_valid = '0;
    logic [2*W-1:0] req_a = '0;
    logic [2*W-1:0] req_b = '0;
    logic [1:0]     req_ready;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [W-1:0]   rsp_sum;
    logic           rsp_id;
    logic           rsp_ovf;
    int             n_tests = 0;
    int             n_fail = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(W), .NREQ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf)
    );

    typedef struct {
        logic [1:0]   v;
        logic [W-1:0] a0, b0, a1, b1;
        logic         rr;
        logic [1:0]   rdy;
        logic         vld;
        logic [W-1:0] sum;
        logic         id;
        logic         ovf;
    } vec_t;

    vec_t tbl[14];

    // Reference state: one result slot plus the requester that won last.
    logic         m_full, m_id, m_ovf, m_last;
    logic [W-1:0] m_sum;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [1:0] v, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input logic rr, output logic [1:0] rdy);
        @(negedge clk);
        rst = r;
        req_valid = v;
        req_a = {a1, a0};
        req_b = {b1, b0};
        rsp_ready = rr;
        #1 rdy = req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic vld, input logic [W-1:0] sum, input logic id, input logic ovf);
        chk({name, ".valid"}, W'(rsp_valid), W'(vld));
        if (vld) begin
            chk({name, ".sum"}, rsp_sum, sum);
            chk({name, ".id"}, W'(rsp_id), W'(id));
            chk({name, ".ovf"}, W'(rsp_ovf), W'(ovf));
        end
    endtask

    task automatic model_step(input logic r, input logic [1:0] v, input logic [W-1:0] a0, input logic [W-1:0] b0,
                              input logic [W-1:0] a1, input logic [W-1:0] b1, input logic rr, output logic [1:0] er);
        int     g;
        longint sa, sb, s, lim;
        er = 2'b00;
        if (r) begin
            m_full = 0; m_sum = '0; m_id = 0; m_ovf = 0; m_last = 1;
        end else if ((!m_full || rr) && v != 2'b00) begin
            g = (v == 2'b11) ? 1 - int'(m_last) : (v == 2'b10 ? 1 : 0);
            er = 2'(1 << g);
            sa = longint'($signed(g == 1 ? a1 : a0));
            sb = longint'($signed(g == 1 ? b1 : b0));
            s = sa + sb;
            lim = longint'(1) << (W - 1);
            m_sum = s[W-1:0];
            m_ovf = OVF && (s >= lim || s < -lim);
            m_id = (g == 1);
            m_last = (g == 1);
            m_full = 1;
        end else if (rr) begin
            m_full = 0;
        end
    endtask

    initial begin
        logic [1:0]   rdy, er;
        logic [1:0]   v;
        logic [W-1:0] a0, b0, a1, b1;
        logic         rr, r;

        tbl[0]  = '{2'b01, 5, 7, 0, 0, 1'b1, 2'b01, 1'b1, 12, 1'b0, 1'b0};
        tbl[1]  = '{2'b10, 0, 0, 32'hFFFFFFFF, 1, 1'b1, 2'b10, 1'b1, 0, 1'b1, 1'b0};
        tbl[2]  = '{2'b01, 32'h7FFFFFFF, 1, 0, 0, 1'b1, 2'b01, 1'b1, 32'h80000000, 1'b0, OVF};
        tbl[3]  = '{2'b10, 0, 0, 3, 4, 1'b0, 2'b00, 1'b1, 32'h80000000, 1'b0, OVF};
        tbl[4]  = '{2'b10, 0, 0, 3, 4, 1'b0, 2'b00, 1'b1, 32'h80000000, 1'b0, OVF};
        tbl[5]  = '{2'b10, 0, 0, 3, 4, 1'b0, 2'b00, 1'b1, 32'h80000000, 1'b0, OVF};
        tbl[6]  = '{2'b10, 0, 0, 3, 4, 1'b1, 2'b10, 1'b1, 7, 1'b1, 1'b0};
        tbl[7]  = '{2'b00, 0, 0, 0, 0, 1'b1, 2'b00, 1'b0, 0, 1'b0, 1'b0};
        tbl[8]  = '{2'b00, 0, 0, 0, 0, 1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b0};
        tbl[9]  = '{2'b11, 100, 200, 1, 1, 1'b0, 2'b01, 1'b1, 300, 1'b0, 1'b0};
        tbl[10] = '{2'b11, 100, 200, 1, 1, 1'b0, 2'b00, 1'b1, 300, 1'b0, 1'b0};
        tbl[11] = '{2'b00, 0, 0, 0, 0, 1'b1, 2'b00, 1'b0, 0, 1'b0, 1'b0};
        tbl[12] = '{2'b11, 100, 200, 1, 1, 1'b0, 2'b10, 1'b1, 2, 1'b1, 1'b0};
        tbl[13] = '{2'b01, 32'h80000000, 32'h80000000, 0, 0, 1'b1, 2'b01, 1'b1, 0, 1'b0, OVF};

        apply(1, 2'b11, 1, 1, 1, 1, 1, rdy);
        chk("rst.ready", W'(rdy), 0);
        chk("rst.valid", W'(rsp_valid), 0);
        chk("rst.sum", rsp_sum, 0);
        chk("rst.id", W'(rsp_id), 0);
        chk("rst.ovf", W'(rsp_ovf), 0);

        for (int i = 0; i < 14; i++) begin
            apply(0, tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, tbl[i].rr, rdy);
            chk($sformatf("vec%0d.ready", i), W'(rdy), W'(tbl[i].rdy));
            chk_out($sformatf("vec%0d", i), tbl[i].vld, tbl[i].sum, tbl[i].id, tbl[i].ovf);
        end

        // Contention straight after reset alternates 0,1,0,1.
        apply(1, 2'b00, 0, 0, 0, 0, 0, rdy);
        for (int i = 0; i < 4; i++) begin
            apply(0, 2'b11, 10, 1, 20, 2, 1, rdy);
            chk($sformatf("rr%0d.ready", i), W'(rdy), (i % 2 == 0) ? 1 : 2);
            chk_out($sformatf("rr%0d", i), 1'b1, (i % 2 == 0) ? 11 : 22, (i % 2 == 1), 1'b0);
        end

        // Reset while FULL after requester 0 won: requester 0 must still win next.
        apply(0, 2'b01, 4, 4, 0, 0, 1, rdy);
        apply(0, 2'b00, 0, 0, 0, 0, 0, rdy);
        chk_out("mid.full", 1'b1, 8, 1'b0, 1'b0);
        apply(1, 2'b11, 4, 4, 9, 9, 1, rdy);
        chk("mid.rst_ready", W'(rdy), 0);
        chk("mid.rst_valid", W'(rsp_valid), 0);
        apply(0, 2'b11, 4, 4, 9, 9, 1, rdy);
        chk("mid.ready", W'(rdy), 1);
        chk_out("mid.after", 1'b1, 8, 1'b0, 1'b0);

        model_step(1, 0, 0, 0, 0, 0, 0, er);
        apply(1, 2'b00, 0, 0, 0, 0, 0, rdy);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            v  = 2'($urandom_range(0, 3));
            a0 = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
            b0 = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            b1 = $urandom;
            rr = ($urandom_range(0, 9) < 7);
            model_step(r, v, a0, b0, a1, b1, rr, er);
            apply(r, v, a0, b0, a1, b1, rr, rdy);
            chk($sformatf("rnd%0d.ready", i), W'(rdy), W'(er));
            chk_out($sformatf("rnd%0d", i), m_full, m_sum, m_id, m_ovf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
